// File: rtl/ascon_sbox_lut_seq_if.sv
// Request/result/table-programming bundle for ascon_sbox_lut_seq.
// The slave modport is the engine side; the master modport is the requester/programmer side.
interface ascon_sbox_lut_seq_if #(
    parameter int NUM_LANES = 64,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 5
);
    logic                                in_valid_i;
    logic                                in_ready_o;
    logic [NUM_LANES-1:0][ADDR_W-1:0]    in_addr_i;
    logic                                out_valid_o;
    logic                                out_ready_i;
    logic [NUM_LANES-1:0][DATA_W-1:0]    out_data_o;
    logic                                tbl_we_i;
    logic [ADDR_W-1:0]                   tbl_addr_i;
    logic [DATA_W-1:0]                   tbl_wdata_i;
    logic [DATA_W-1:0]                   tbl_rdata_o;
    logic                                busy_o;
    logic                                tbl_err_o;

    modport slave (
        input  in_valid_i, in_addr_i, out_ready_i, tbl_we_i, tbl_addr_i, tbl_wdata_i,
        output in_ready_o, out_valid_o, out_data_o, tbl_rdata_o, busy_o, tbl_err_o
    );

    modport master (
        output in_valid_i, in_addr_i, out_ready_i, tbl_we_i, tbl_addr_i, tbl_wdata_i,
        input  in_ready_o, out_valid_o, out_data_o, tbl_rdata_o, busy_o, tbl_err_o
    );
endinterface

// File: rtl/ascon_sbox_lut_seq.sv
// Time-multiplexed ASCON S-box lookup: LUT_PORTS lanes per cycle against a programmable table.
// Optional macro ASCON_SBOX_LUT_RESET_TABLE_EN makes the table reset to the ASCON S-box (else to zero).
module ascon_sbox_lut_seq #(
    parameter int NUM_LANES = 64,
    parameter int LUT_PORTS = 8,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    ascon_sbox_lut_seq_if.slave  bus
);
    localparam int NUM_BEATS = NUM_LANES / LUT_PORTS;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int DEPTH     = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                              state_r;
    state_t                              state_nxt_s;
    logic [CNT_W-1:0]                    cnt_r;
    logic [NUM_LANES-1:0][ADDR_W-1:0]    addr_r;
    logic [NUM_LANES-1:0][DATA_W-1:0]    data_r;
    logic [DATA_W-1:0]                   table_r [DEPTH];
    logic [LUT_PORTS-1:0][DATA_W-1:0]    beat_s;
    logic                                last_beat_s;
    logic                                tbl_err_r;

`ifdef ASCON_SBOX_LUT_RESET_TABLE_EN
    function automatic logic [DATA_W-1:0] reset_entry(input logic [4:0] idx);
        logic [4:0] s;
        case (idx)
            5'h00: s = 5'h04;  5'h01: s = 5'h0B;  5'h02: s = 5'h1F;  5'h03: s = 5'h14;
            5'h04: s = 5'h1A;  5'h05: s = 5'h15;  5'h06: s = 5'h09;  5'h07: s = 5'h02;
            5'h08: s = 5'h1B;  5'h09: s = 5'h05;  5'h0A: s = 5'h08;  5'h0B: s = 5'h12;
            5'h0C: s = 5'h1D;  5'h0D: s = 5'h03;  5'h0E: s = 5'h06;  5'h0F: s = 5'h1C;
            5'h10: s = 5'h1E;  5'h11: s = 5'h13;  5'h12: s = 5'h07;  5'h13: s = 5'h0E;
            5'h14: s = 5'h00;  5'h15: s = 5'h0D;  5'h16: s = 5'h11;  5'h17: s = 5'h18;
            5'h18: s = 5'h10;  5'h19: s = 5'h0C;  5'h1A: s = 5'h01;  5'h1B: s = 5'h19;
            5'h1C: s = 5'h16;  5'h1D: s = 5'h0A;  5'h1E: s = 5'h0F;  5'h1F: s = 5'h17;
            default: s = 5'h00;
        endcase
        return DATA_W'(s);
    endfunction
`endif

    assign last_beat_s = (cnt_r == CNT_W'(NUM_BEATS - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; DONE always returns through IDLE before a new capture
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid_i) state_nxt_s = ST_LOOKUP;
                else                state_nxt_s = ST_IDLE;
            end
            ST_LOOKUP: begin
                if (last_beat_s) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_LOOKUP;
            end
            ST_DONE: begin
                if (bus.out_ready_i) state_nxt_s = ST_IDLE;
                else                 state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Table reads for the lanes of the current beat
    always_comb begin
        beat_s = '0;
        for (int p = 0; p < LUT_PORTS; p++) begin
            beat_s[p] = table_r[addr_r[LANE_W'(int'(cnt_r) * LUT_PORTS + p)]];
        end
    end

    // Address capture, beat counter, result lanes and the dropped-write flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_r    <= '0;
            data_r    <= '0;
            cnt_r     <= '0;
            tbl_err_r <= 1'b0;
        end else begin
            tbl_err_r <= bus.tbl_we_i && (state_r != ST_IDLE);
            if ((state_r == ST_IDLE) && bus.in_valid_i) begin
                addr_r <= bus.in_addr_i;
                cnt_r  <= '0;
            end else if (state_r == ST_LOOKUP) begin
                for (int p = 0; p < LUT_PORTS; p++) begin
                    data_r[LANE_W'(int'(cnt_r) * LUT_PORTS + p)] <= beat_s[p];
                end
                cnt_r <= last_beat_s ? '0 : cnt_r + 1'b1;
            end
        end
    end

    // Table storage: writable only while idle so every request sees one coherent table
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef ASCON_SBOX_LUT_RESET_TABLE_EN
                table_r[i] <= reset_entry(5'(i));
`else
                table_r[i] <= '0;
`endif
            end
        end else if (bus.tbl_we_i && (state_r == ST_IDLE)) begin
            table_r[bus.tbl_addr_i] <= bus.tbl_wdata_i;
        end
    end

    assign bus.in_ready_o  = (state_r == ST_IDLE);
    assign bus.out_valid_o = (state_r == ST_DONE);
    assign bus.busy_o      = (state_r != ST_IDLE);
    assign bus.out_data_o  = data_r;
    assign bus.tbl_rdata_o = table_r[bus.tbl_addr_i];
    assign bus.tbl_err_o   = tbl_err_r;
endmodule
